// File: rtl/neuron_pkg.sv
// Shared types and constants for the neuron MAC datapath.
package neuron_pkg;

    localparam int OPERAND_W = 4;
    localparam int PRODUCT_W = 8;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } mac_state_e;

    function automatic int count_w(input int max_terms);
        return $clog2(max_terms) + 1;
    endfunction

endpackage

// File: rtl/multiplier_4bit.sv
// Combinational 4x4 unsigned multiplier producing a full-width 8-bit product.
module multiplier_4bit
    import neuron_pkg::*;
(
    input  logic [OPERAND_W-1:0] a_i,
    input  logic [OPERAND_W-1:0] b_i,
    output logic [PRODUCT_W-1:0] product_o
);

    assign product_o = PRODUCT_W'(a_i) * PRODUCT_W'(b_i);

endmodule

// File: rtl/neuron_mac_accumulator.sv
// Streaming multiply-accumulate stage with valid/ready on both sides.
// Optional signed bias with ReLU clamp enabled by macro NEURON_MAC_RELU_BIAS_EN.
module neuron_mac_accumulator
    import neuron_pkg::*;
#(
    parameter int MAX_TERMS = 16,
    parameter int ACC_W     = 12
)(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [OPERAND_W-1:0]          in_a,
    input  logic [OPERAND_W-1:0]          in_w,
    input  logic                          in_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ACC_W-1:0]              out_sum,
    output logic [count_w(MAX_TERMS)-1:0] out_terms,
    output logic                          out_ovf
`ifdef NEURON_MAC_RELU_BIAS_EN
    ,
    input  logic signed [ACC_W:0]         bias
`endif
);

    localparam int CNT_W = count_w(MAX_TERMS);
    localparam logic [ACC_W-1:0] ACC_MAX = {ACC_W{1'b1}};

    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                                 input logic [PRODUCT_W-1:0] p);
        logic [ACC_W:0] s;
        s = {1'b0, a} + {{(ACC_W + 1 - PRODUCT_W){1'b0}}, p};
        return s[ACC_W] ? ACC_MAX : s[ACC_W-1:0];
    endfunction

    mac_state_e           state_q;
    logic [PRODUCT_W-1:0] prod_s;
    logic [PRODUCT_W-1:0] prod_q;
    logic                 prod_vld_q;
    logic                 prod_last_q;
    logic [ACC_W-1:0]     acc_q;
    logic [ACC_W-1:0]     acc_d;
    logic [ACC_W-1:0]     acc_sum_s;
    logic [ACC_W-1:0]     fin_sum_d;
    logic [CNT_W-1:0]     count_q;
    logic                 ovf_sticky_q;
    logic                 in_ready_q;
    logic                 out_valid_q;
    logic [ACC_W-1:0]     out_sum_q;
    logic [CNT_W-1:0]     out_terms_q;
    logic                 out_ovf_q;
    logic                 accept_s;
    logic                 at_limit_s;
    logic                 close_s;
`ifdef NEURON_MAC_RELU_BIAS_EN
    logic signed [ACC_W:0]   bias_q;
    logic signed [ACC_W+1:0] biased_s;
`endif

    multiplier_4bit u_mul (
        .a_i       (in_a),
        .b_i       (in_w),
        .product_o (prod_s)
    );

    assign accept_s   = in_valid && in_ready_q;
    assign at_limit_s = (count_q == CNT_W'(MAX_TERMS - 1));
    assign close_s    = in_last || at_limit_s;

    // Next accumulator value and the closing sum produced in DRAIN.
    always_comb begin
        acc_sum_s = sat_add(acc_q, prod_q);
        if (prod_vld_q && !prod_last_q) begin
            acc_d = acc_sum_s;
        end else begin
            acc_d = acc_q;
        end
`ifdef NEURON_MAC_RELU_BIAS_EN
        biased_s = $signed({2'b00, (prod_vld_q ? acc_sum_s : acc_q)})
                 + $signed({bias_q[ACC_W], bias_q});
        if (biased_s[ACC_W+1]) begin
            fin_sum_d = {ACC_W{1'b0}};
        end else if (biased_s[ACC_W]) begin
            fin_sum_d = ACC_MAX;
        end else begin
            fin_sum_d = biased_s[ACC_W-1:0];
        end
`else
        if (prod_vld_q) begin
            fin_sum_d = acc_sum_s;
        end else begin
            fin_sum_d = acc_q;
        end
`endif
    end

    // MAC control FSM with product pipe, accumulator and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ACCUM;
            prod_q       <= {PRODUCT_W{1'b0}};
            prod_vld_q   <= 1'b0;
            prod_last_q  <= 1'b0;
            acc_q        <= {ACC_W{1'b0}};
            count_q      <= {CNT_W{1'b0}};
            ovf_sticky_q <= 1'b0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            out_sum_q    <= {ACC_W{1'b0}};
            out_terms_q  <= {CNT_W{1'b0}};
            out_ovf_q    <= 1'b0;
`ifdef NEURON_MAC_RELU_BIAS_EN
            bias_q       <= {(ACC_W + 1){1'b0}};
`endif
        end else begin
            case (state_q)
                ACCUM: begin
                    acc_q      <= acc_d;
                    prod_vld_q <= accept_s;
                    if (accept_s) begin
                        prod_q      <= prod_s;
                        prod_last_q <= close_s;
                        count_q     <= count_q + CNT_W'(1);
`ifdef NEURON_MAC_RELU_BIAS_EN
                        if (count_q == {CNT_W{1'b0}}) begin
                            bias_q <= bias;
                        end
`endif
                        // Hitting the term limit without last closes the sum early.
                        if (at_limit_s && !in_last) begin
                            ovf_sticky_q <= 1'b1;
                        end
                        if (close_s) begin
                            in_ready_q <= 1'b0;
                            state_q    <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    out_sum_q   <= fin_sum_d;
                    out_terms_q <= count_q;
                    out_ovf_q   <= ovf_sticky_q;
                    out_valid_q <= 1'b1;
                    prod_vld_q  <= 1'b0;
                    prod_last_q <= 1'b0;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        acc_q        <= {ACC_W{1'b0}};
                        count_q      <= {CNT_W{1'b0}};
                        ovf_sticky_q <= 1'b0;
                        out_valid_q  <= 1'b0;
                        in_ready_q   <= 1'b1;
                        state_q      <= ACCUM;
                    end
                end
                default: begin
                    state_q <= ACCUM;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_terms = out_terms_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_neuron_mac_accumulator.sv
// Directed self-checking bench for neuron_mac_accumulator.
module tb_neuron_mac_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_a;
    logic [3:0]  in_w;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_sum;
    logic [4:0]  out_terms;
    logic        out_ovf;
`ifdef NEURON_MAC_RELU_BIAS_EN
    logic signed [12:0] bias;
`endif

    int checks = 0;
    int errors = 0;

    neuron_mac_accumulator #(.MAX_TERMS(16), .ACC_W(12)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_w      (in_w),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_terms (out_terms),
        .out_ovf   (out_ovf)
`ifdef NEURON_MAC_RELU_BIAS_EN
        ,
        .bias      (bias)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [3:0] a, input logic [3:0] w, input logic last);
        in_valid = 1'b1;
        in_a     = a;
        in_w     = w;
        in_last  = last;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic check_result(input string tag, input logic [31:0] sum,
                                input logic [31:0] terms, input logic [31:0] ovf);
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_sum"},   {20'd0, out_sum},   sum);
        check({tag, "_terms"}, {27'd0, out_terms}, terms);
        check({tag, "_ovf"},   {31'd0, out_ovf},   ovf);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_a = 4'd0; in_w = 4'd0; in_last = 1'b0; out_ready = 1'b1;
`ifdef NEURON_MAC_RELU_BIAS_EN
        bias = 13'sd0;
`endif
        step(); step();
        rst = 1'b0;
        check("rst_in_ready",  {31'd0, in_ready},  32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_sum",   {20'd0, out_sum},   32'd0);
        check("rst_out_terms", {27'd0, out_terms}, 32'd0);
        check("rst_out_ovf",   {31'd0, out_ovf},   32'd0);

        // Three-term dot product, valid two cycles after last accept.
        send(4'd3, 4'd5, 1'b0);
        send(4'd15, 4'd15, 1'b0);
        send(4'd2, 4'd7, 1'b1);
        check("t1_valid_t1", {31'd0, out_valid}, 32'd0);
        check("t1_ready_drain", {31'd0, in_ready}, 32'd0);
        step();
        check_result("t1", 32'd254, 32'd3, 32'd0);
        step();
        check("t1_hs_valid", {31'd0, out_valid}, 32'd0);
        check("t1_hs_ready", {31'd0, in_ready},  32'd1);

        // Full fan-in of 16 max products.
        for (int i = 0; i < 16; i++) send(4'd15, 4'd15, (i == 15) ? 1'b1 : 1'b0);
        step();
        check_result("t2", 32'd3600, 32'd16, 32'd0);
        step();

        // 17-pair attempt without last: closes at 16 with overflow.
        for (int i = 0; i < 16; i++) send(4'd15, 4'd15, 1'b0);
        check("t3_ready_closed", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b1; in_a = 4'd1; in_w = 4'd2; in_last = 1'b1;
        step();
        check_result("t3", 32'd3600, 32'd16, 32'd1);
        step();
        check("t3_hs_valid", {31'd0, out_valid}, 32'd0);
        check("t3_hs_ready", {31'd0, in_ready},  32'd1);
        step();
        in_valid = 1'b0; in_last = 1'b0;
        step();
        check_result("t3_next", 32'd2, 32'd1, 32'd0);
        step();

        // Backpressure: result held stable, no accept while waiting.
        out_ready = 1'b0;
        send(4'd9, 4'd4, 1'b1);
        step();
        in_valid = 1'b1; in_a = 4'd7; in_w = 4'd7; in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("t4_hold_valid", {31'd0, out_valid}, 32'd1);
            check("t4_hold_sum",   {20'd0, out_sum},   32'd36);
            check("t4_hold_ready", {31'd0, in_ready},  32'd0);
            step();
        end
        out_ready = 1'b1;
        step();
        check("t4_hs_valid", {31'd0, out_valid}, 32'd0);
        check("t4_hs_ready", {31'd0, in_ready},  32'd1);
        step();
        in_valid = 1'b0; in_last = 1'b0;
        step();
        check_result("t4_next", 32'd49, 32'd1, 32'd0);
        step();

        // Bubbles between every pair.
        send(4'd1, 4'd1, 1'b0); step();
        send(4'd2, 4'd2, 1'b0); step();
        send(4'd3, 4'd3, 1'b0); step();
        send(4'd4, 4'd4, 1'b1); step();
        check_result("t5", 32'd30, 32'd4, 32'd0);
        step();

        // Reset during DRAIN discards everything.
        send(4'd5, 4'd5, 1'b0);
        send(4'd6, 4'd6, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6_rst_valid", {31'd0, out_valid}, 32'd0);
        check("t6_rst_ready", {31'd0, in_ready},  32'd1);
        check("t6_rst_sum",   {20'd0, out_sum},   32'd0);
        send(4'd6, 4'd6, 1'b1);
        step();
        check_result("t6", 32'd36, 32'd1, 32'd0);
        step();

`ifdef NEURON_MAC_RELU_BIAS_EN
        bias = -13'sd40;
        send(4'd5, 4'd5, 1'b0);
        bias = 13'sd0;
        send(4'd2, 4'd2, 1'b1);
        step();
        check_result("t7_neg", 32'd0, 32'd2, 32'd0);
        step();
        bias = 13'sd10;
        send(4'd5, 4'd5, 1'b0);
        bias = 13'sd0;
        send(4'd2, 4'd2, 1'b1);
        step();
        check_result("t7_pos", 32'd39, 32'd2, 32'd0);
        step();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
